// File: rtl/instr_fetch_pkg.sv
// ============================================================================
// Module : instr_fetch_pkg
// Shared definitions for the instruction-fetch unit: widths, opcodes, FSM states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package instr_fetch_pkg;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_LD   = 4'h3,
    OP_ST   = 4'h4,
    OP_BR   = 4'h8,
    OP_JMP  = 4'h9,
    OP_HALT = 4'hF
  } opcode_t;

  localparam logic [3:0] HALT_OP = OP_HALT;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_next_pc.sv
// ============================================================================
// Module : next_pc
// Next-PC selection: jump beats taken branch, otherwise sequential (wraps).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module next_pc #(
  parameter int PC_W = 10
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] target_i,
  input  logic            br_ctrl_i,
  input  logic            br_taken_i,
  input  logic            jmp_ctrl_i,
  output logic [PC_W-1:0] next_pc_o
);

  logic [PC_W-1:0] seq_pc;

  assign seq_pc = pc_i + {{(PC_W-1){1'b0}}, 1'b1};

  always_comb begin
    next_pc_o = seq_pc;
    if (jmp_ctrl_i) begin
      next_pc_o = target_i;
    end else if (br_ctrl_i && br_taken_i) begin
      next_pc_o = target_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module : instr_fetch
// Fetch/issue sequencer: IDLE -> FETCH -> ISSUE -> (FETCH | HALT).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter int PC_W    = instr_fetch_pkg::PC_W,
  parameter int INSTR_W = instr_fetch_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hold,
  input  logic               br_ctrl,
  input  logic               jmp_ctrl,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               typ,
  output logic [3:0]         op,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               done
);

  import instr_fetch_pkg::*;

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc_seq_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               is_halt;

  next_pc #(.PC_W(PC_W)) u_next_pc (
    .pc_i       (pc_q),
    .target_i   (target),
    .br_ctrl_i  (br_ctrl),
    .br_taken_i (br_taken),
    .jmp_ctrl_i (jmp_ctrl),
    .next_pc_o  (pc_seq_d)
  );

  assign is_halt = ~instr_q[INSTR_W-1] && (instr_q[INSTR_W-2 -: 4] == HALT_OP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A halting instruction freezes pc at its own address.
        if (!hold) begin
          if (is_halt) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_seq_d;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == S_FETCH);
    instr_valid = (state_q == S_ISSUE);
    done        = (state_q == S_HALT);
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign typ       = instr_q[INSTR_W-1];
  assign op        = instr_q[INSTR_W-2 -: 4];

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module : tb_instr_fetch
// Scoreboard bench for instr_fetch: memory responder plus next-PC reference.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;

  logic               clk = 1'b0;
  logic               rst_n, start, hold, br_ctrl, jmp_ctrl, br_taken;
  logic [PC_W-1:0]    target;
  logic               imem_req, imem_ack;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata, instr;
  logic               typ, instr_valid, done;
  logic [3:0]         op;
  logic [PC_W-1:0]    pc;

  instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .hold        (hold),
    .br_ctrl     (br_ctrl),
    .jmp_ctrl    (jmp_ctrl),
    .br_taken    (br_taken),
    .target      (target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .typ         (typ),
    .op          (op),
    .instr_valid (instr_valid),
    .pc          (pc),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [PC_W-1:0]    addr;
    logic [INSTR_W-1:0] data;
  } sb_entry_t;

  sb_entry_t          sb_q[$];
  logic [PC_W-1:0]    exp_pc;
  logic [INSTR_W-1:0] last_instr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_pc"},    32'(pc),          32'd0);
    check({tag, "_instr"}, 32'(instr),       32'd0);
    check({tag, "_req"},   32'(imem_req),    32'd0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_done"},  32'(done),        32'd0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    exp_pc = '0;
  endtask

  // Serve one fetch after 'delay' wait cycles; result is checked when issued.
  task automatic fetch(input logic [INSTR_W-1:0] data, input int delay);
    sb_entry_t e;
    int        budget = 20;
    while (!imem_req && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!imem_req) begin
      check("req_timeout", 32'(imem_req), 32'd1);
      return;
    end
    for (int i = 0; i < delay; i++) begin
      check("wait_req",   32'(imem_req),    32'd1);
      check("wait_addr",  32'(imem_addr),   32'(exp_pc));
      check("wait_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
    end
    check("ack_addr", 32'(imem_addr), 32'(exp_pc));
    imem_ack   = 1'b1;
    imem_rdata = data;
    sb_q.push_back('{addr: exp_pc, data: data});
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = INSTR_W'($urandom);
    check("issue_valid", 32'(instr_valid), 32'd1);
    check("issue_req",   32'(imem_req),    32'd0);
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("issue_instr", 32'(instr), 32'(e.data));
      check("issue_typ",   32'(typ),   32'(e.data[8]));
      check("issue_op",    32'(op),    32'(e.data[7:4]));
      check("issue_pc",    32'(pc),    32'(e.addr));
      last_instr = e.data;
    end
  endtask

  // Hold for nhold cycles (with stray ack/start poked in), then release with controls.
  task automatic issue(input int nhold, input logic br, input logic tk,
                       input logic jmp, input logic [PC_W-1:0] tgt);
    logic halt_ins;
    for (int i = 0; i < nhold; i++) begin
      hold       = 1'b1;
      imem_ack   = (i == 1);
      imem_rdata = 9'h1AA;
      start      = (i == 2);
      @(negedge clk);
      imem_ack = 1'b0;
      start    = 1'b0;
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_pc",    32'(pc),          32'(exp_pc));
      check("hold_instr", 32'(instr),       32'(last_instr));
    end
    hold     = 1'b0;
    br_ctrl  = br;
    br_taken = tk;
    jmp_ctrl = jmp;
    target   = tgt;
    @(negedge clk);
    br_ctrl  = 1'b0;
    br_taken = 1'b0;
    jmp_ctrl = 1'b0;
    halt_ins = (last_instr[8] == 1'b0) && (last_instr[7:4] == 4'hF);
    if (halt_ins) begin
      check("halt_done", 32'(done),     32'd1);
      check("halt_pc",   32'(pc),       32'(exp_pc));
      check("halt_req",  32'(imem_req), 32'd0);
    end else begin
      if (jmp)           exp_pc = tgt;
      else if (br && tk) exp_pc = tgt;
      else               exp_pc = exp_pc + 1'b1;
      check("next_req",  32'(imem_req),  32'd1);
      check("next_addr", 32'(imem_addr), 32'(exp_pc));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; hold = 1'b0; br_ctrl = 1'b0; jmp_ctrl = 1'b0;
    br_taken = 1'b0; target = '0; imem_ack = 1'b0; imem_rdata = '0;
    exp_pc = '0; last_instr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_idle_zero("reset");

    // Zero-wait fetch of 9'h105, then sequential advance to pc 1.
    do_start();
    fetch(9'h105, 0);
    issue(0, 1'b0, 1'b0, 1'b0, '0);

    // Ack delayed 3 cycles, then jump to 12.
    fetch(9'h023, 3);
    issue(0, 1'b0, 1'b0, 1'b1, 10'd12);

    // Branch not taken, taken, and jump-over-branch at pc 12.
    fetch(9'h081, 0);
    issue(0, 1'b1, 1'b0, 1'b0, 10'd40);
    fetch(9'h082, 1);
    issue(0, 1'b0, 1'b0, 1'b1, 10'd12);
    fetch(9'h083, 0);
    issue(0, 1'b1, 1'b1, 1'b0, 10'd40);
    fetch(9'h090, 2);
    issue(0, 1'b0, 1'b0, 1'b1, 10'd12);
    fetch(9'h091, 0);
    issue(0, 1'b1, 1'b0, 1'b1, 10'd7);

    // Wrap from 1023 after a 5-cycle hold.
    fetch(9'h092, 0);
    issue(0, 1'b0, 1'b0, 1'b1, 10'd1023);
    fetch(9'h113, 0);
    issue(5, 1'b0, 1'b0, 1'b0, '0);

    // HALT then restart.
    fetch(9'h0F0, 0);
    issue(0, 1'b0, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    check("halt_stay_done", 32'(done), 32'd1);
    check("halt_stay_pc",   32'(pc),   32'd0);
    do_start();
    check("restart_done", 32'(done),      32'd0);
    check("restart_req",  32'(imem_req),  32'd1);
    check("restart_addr", 32'(imem_addr), 32'd0);
    fetch(9'h1F0, 0);
    issue(0, 1'b0, 1'b0, 1'b1, 10'd5);

    // Reset in the middle of a fetch; a late ack must be ignored.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_zero("midfetch_rst");
    imem_ack   = 1'b1;
    imem_rdata = 9'h155;
    @(negedge clk);
    imem_ack = 1'b0;
    check_idle_zero("late_ack");

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The parameter PC_W SHALL default to 10 and set the program-counter width.
REQ-002 The parameter INSTR_W SHALL default to 9 and set the instruction width: [8]=TYP, [7:4]=OP, [3:0]=operand.
REQ-003 clk  in  1  Single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  Reset, synchronous and active-low.
REQ-005 start  in  1  Begin execution at PC 0; honoured only in IDLE or HALT.
REQ-006 hold  in  1  Datapath stall; keeps the current instruction issued.
REQ-007 br_ctrl  in  1  Branch control from the decoder for the issued instruction.
REQ-008 jmp_ctrl  in  1  Jump control from the decoder for the issued instruction.
REQ-009 br_taken  in  1  Branch condition from the datapath.
REQ-010 target  in  PC_W  Branch/jump destination address.
REQ-011 imem_req  out  1  Instruction-memory read request.
REQ-012 imem_addr  out  PC_W  Read address; SHALL equal pc.
REQ-013 imem_ack  in  1  One-cycle read completion; imem_rdata is valid with it.
REQ-014 imem_rdata  in  INSTR_W  Fetched word.
REQ-015 instr  out  INSTR_W  Registered current instruction.
REQ-016 typ  out  1  instr[8], driven to the decoder TYP input.
REQ-017 op  out  4  instr[7:4], driven to the decoder OP input.
REQ-018 instr_valid  out  1  High while instr is issued to the decoder and datapath.
REQ-019 pc  out  PC_W  Address of the current instruction.
REQ-020 done  out  1  High while in HALT.

Function
REQ-021 The FSM SHALL have four states: IDLE, FETCH, ISSUE and HALT.
REQ-022 IDLE: when start=1, the block SHALL load pc=0 and enter FETCH on the next cycle.
REQ-023 FETCH: imem_req SHALL be 1 and imem_addr SHALL be held stable until imem_ack.
REQ-024 FETCH: on imem_ack, instr SHALL capture imem_rdata, imem_req SHALL drop on the following cycle, and the FSM SHALL enter ISSUE.
REQ-025 ISSUE: instr_valid SHALL be 1.
REQ-026 ISSUE with hold=1: the FSM SHALL remain in ISSUE with pc and instr unchanged.
REQ-027 ISSUE with hold=0: next pc SHALL be target when jmp_ctrl=1.
REQ-028 Otherwise next pc SHALL be target when br_ctrl=1 and br_taken=1.
REQ-029 Otherwise next pc SHALL be pc+1 modulo 2^PC_W, so 1023 wraps to 0.
REQ-030 After updating pc per REQ-027 to REQ-029, the FSM SHALL return to FETCH.
REQ-031 If jmp_ctrl and br_ctrl are both 1, jmp_ctrl SHALL take priority.
REQ-032 A HALT instruction (typ=0, op=HALT_OP=4'hF) in ISSUE with hold=0 SHALL leave pc unchanged and enter HALT.
REQ-033 HALT: done=1; start=1 SHALL clear done, set pc=0 and enter FETCH.
REQ-034 Minimum throughput SHALL be one instruction per 2 cycles plus memory latency; with ack in the first FETCH cycle, one instruction per 2 cycles.
REQ-035 imem_ack outside FETCH SHALL be ignored.
REQ-036 start outside IDLE/HALT SHALL be ignored.
REQ-037 imem_req and instr_valid SHALL never be high in the same cycle.

Reset
REQ-038 On a clk edge with rst_n=0, the FSM SHALL go to IDLE and pc, instr, imem_req, instr_valid and done SHALL all become 0.
REQ-039 Reset SHALL take precedence over every other input, including mid-FETCH (request abandoned; a later ack is ignored) and mid-ISSUE.

Structure
REQ-040 PC_W, INSTR_W, HALT_OP and the fetch_state_t enum SHALL live in the shared definitions package alongside the opcode enum.
REQ-041 Next-PC selection SHALL be a sub-module, next_pc, taking pc, target, br_ctrl, br_taken and jmp_ctrl.
REQ-042 The FSM and registers SHALL remain in instr_fetch.

Verification
REQ-043 Reset then start: memory returns 9'h1_05 with zero-wait ack; instr=9'h105, typ=1, instr_valid in cycle 3, then pc=1.
REQ-044 Ack delayed 3 cycles: imem_req held 4 cycles, imem_addr stable, no instr_valid until the ack.
REQ-045 ISSUE at pc=12 with br_ctrl=1, br_taken=0, target=40: next fetch at 13; with br_taken=1: next fetch at 40; with jmp_ctrl=1 and br_ctrl=1, target=7: next fetch at 7.
REQ-046 pc=1023, ordinary instruction: next fetch at address 0; hold=1 for 5 cycles in ISSUE: pc and instr unchanged, instr_valid high throughout.
REQ-047 Fetch 9'h0_F0 (HALT): done=1, pc frozen; start restarts at 0 and done clears.
REQ-048 rst_n=0 mid-FETCH, then ack arrives: IDLE, all outputs 0, ack ignored.
